// File: rtl/counter_seq_pkg.sv
// Shared types and defaults for the counter sequencer slice.
// Pure declarations: no logic, no latency, no flow control.
package counter_seq_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int REPS_W_DEF = 4;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sync_updown_counter.sv
// Loadable mod-2^WIDTH up/down counter; load beats enable, one step per clock.
// Result visible the cycle after the edge; no backpressure, caller gates en.
module sync_updown_counter
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      // Natural overflow of the WIDTH-bit sum gives the 15->0 / 0->15 wrap.
      cnt_d = (dir == MODE_DOWN) ? cnt_q - 1'b1 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/counter_sequencer.sv
// Sequences programmed up/down counter runs with repeat, pause and abort.
// Start takes effect at the sampling edge; pause stalls counting, abort drops to IDLE.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int REPS_W = REPS_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  term_val,
  input  logic [REPS_W-1:0] reps,
  input  logic              pause,
  input  logic              abort,
  output logic [WIDTH-1:0]  q,
  output logic              busy,
  output logic              tick,
  output logic              done,
  output logic [REPS_W-1:0] rep_cnt
);

  state_e            state_q;
  logic              mode_q;
  logic [WIDTH-1:0]  load_q;
  logic [WIDTH-1:0]  term_q;
  logic [REPS_W-1:0] reps_q;
  logic [REPS_W-1:0] rep_cnt_q;
  logic              busy_q;
  logic              tick_q;
  logic              done_q;

  logic              cnt_load;
  logic              cnt_en;
  logic [WIDTH-1:0]  cnt_load_val;
  logic              at_term;
  logic              last_run;
  logic [REPS_W-1:0] rep_next;

  assign at_term  = (q == term_q);
  assign rep_next = rep_cnt_q + 1'b1;
  // reps of zero never matches, which is what makes it run forever.
  assign last_run = (reps_q != '0) && (rep_next == reps_q);

  always_comb begin
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = load_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_load     = 1'b1;
          cnt_load_val = load_val;
        end
      end
      RUN: begin
        if (!abort && !pause) begin
          if (!at_term) begin
            cnt_en = 1'b1;
          end else if (!last_run) begin
            cnt_load = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  sync_updown_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .en      (cnt_en),
    .dir     (mode_q),
    .q       (q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_UP;
      load_q    <= '0;
      term_q    <= '0;
      reps_q    <= '0;
      rep_cnt_q <= '0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            load_q    <= load_val;
            term_q    <= term_val;
            reps_q    <= reps;
            rep_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (pause) begin
            state_q <= HOLD;
          end else if (at_term) begin
            tick_q    <= 1'b1;
            rep_cnt_q <= rep_next;
            if (last_run) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        HOLD: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!pause) begin
            state_q <= RUN;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign tick    = tick_q;
  assign done    = done_q;
  assign rep_cnt = rep_cnt_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: hand-computed per-cycle tables of q/busy/tick/done/rep_cnt.
module tb_counter_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic [3:0] load_val;
  logic [3:0] term_val;
  logic [3:0] reps;
  logic       pause;
  logic       abort;
  logic [3:0] q;
  logic       busy;
  logic       tick;
  logic       done;
  logic [3:0] rep_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Cycle i = outputs seen just after the i-th edge following the start edge.
  int t1_q[10]  = '{3, 4, 5, 6, 3, 4, 5, 6, 6, 6};
  int t1_b[10]  = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int t1_t[10]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
  int t1_d[10]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  int t1_r[10]  = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2};

  int t2_q[6]   = '{1, 0, 15, 14, 14, 14};
  int t2_b[6]   = '{1, 1, 1, 1, 0, 0};
  int t2_t[6]   = '{0, 0, 0, 0, 1, 0};
  int t2_r[6]   = '{0, 0, 0, 0, 1, 1};

  int t3_q[10]  = '{3, 4, 5, 5, 5, 5, 5, 6, 6, 6};
  int t3_b[10]  = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int t3_t[10]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  int t3_r[10]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

  int t4_q[5]   = '{2, 3, 4, 4, 4};
  int t4_b[5]   = '{1, 1, 1, 0, 0};

  counter_sequencer #(
    .WIDTH (4),
    .REPS_W(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .load_val(load_val),
    .term_val(term_val),
    .reps    (reps),
    .pause   (pause),
    .abort   (abort),
    .q       (q),
    .busy    (busy),
    .tick    (tick),
    .done    (done),
    .rep_cnt (rep_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input string t, input int i, input int eq, input int eb,
                     input int et, input int ed, input int er);
    chk($sformatf("%s[%0d].q", t, i),       32'(q),       eq);
    chk($sformatf("%s[%0d].busy", t, i),    32'(busy),    eb);
    chk($sformatf("%s[%0d].tick", t, i),    32'(tick),    et);
    chk($sformatf("%s[%0d].done", t, i),    32'(done),    ed);
    chk($sformatf("%s[%0d].rep_cnt", t, i), 32'(rep_cnt), er);
  endtask

  task automatic go(input logic m, input logic [3:0] lv, input logic [3:0] tv,
                    input logic [3:0] rp);
    mode     = m;
    load_val = lv;
    term_val = tv;
    reps     = rp;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; load_val = '0; term_val = '0;
    reps = '0; pause = 1'b0; abort = 1'b0;
    step();
    step();
    rst = 1'b0;
    cyc("reset", 0, 0, 0, 0, 0, 0);

    // Up, two runs 3..6
    go(1'b0, 4'd3, 4'd6, 4'd2);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      cyc("up2", i, t1_q[i], t1_b[i], t1_t[i], t1_d[i], t1_r[i]);
    end

    // Down through the 0->15 wrap, single run
    go(1'b1, 4'd1, 4'd14, 4'd1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      cyc("down_wrap", i, t2_q[i], t2_b[i], t2_t[i], t2_t[i], t2_r[i]);
    end

    // Pause held for three edges starting while q==5
    go(1'b0, 4'd3, 4'd6, 4'd1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      cyc("pause", i, t3_q[i], t3_b[i], t3_t[i], t3_t[i], t3_r[i]);
      if (i == 2) pause = 1'b1;
      if (i == 5) pause = 1'b0;
    end

    // Abort sampled on the q==term cycle of an endless sequence
    go(1'b0, 4'd2, 4'd4, 4'd0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      cyc("abort", i, t4_q[i], t4_b[i], 0, 0, 0);
      if (i == 2) abort = 1'b1;
      if (i == 3) abort = 1'b0;
    end

    // Endless 1-cycle runs; rep_cnt wraps; start with new values held during RUN
    go(1'b0, 4'd7, 4'd7, 4'd0);
    cyc("inf", 0, 7, 1, 0, 0, 0);
    start = 1'b1; mode = 1'b1; load_val = 4'd0; term_val = 4'd0; reps = 4'd1;
    for (int i = 1; i < 18; i++) begin
      step();
      cyc("inf", i, 7, 1, 1, 0, i % 16);
    end
    start = 1'b0;
    abort = 1'b1;
    step();
    cyc("inf_abort", 18, 7, 0, 0, 0, 1);
    abort = 1'b0;

    // Reset while paused mid-run
    go(1'b0, 4'd9, 4'd12, 4'd3);
    cyc("rst_mid", 0, 9, 1, 0, 0, 0);
    step();
    cyc("rst_mid", 1, 10, 1, 0, 0, 0);
    pause = 1'b1;
    step();
    cyc("rst_mid", 2, 10, 1, 0, 0, 0);
    rst = 1'b1;
    step();
    cyc("rst_mid", 3, 0, 0, 0, 0, 0);
    rst = 1'b0;
    pause = 1'b0;
    step();
    cyc("rst_mid", 4, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Synchronous controller that sequences a 4-bit up/down counter datapath through programmed runs. A run loads a start value and counts one step per clock toward a terminal value; the run is repeated a programmed number of times or indefinitely. Pause, abort and a start/busy/done handshake are provided. It sits between control logic and the counter datapath, replacing free-running ripple counting with a fully clocked, parameterised sequencer.

## Interface
- WIDTH, 4: counter width in bits.
- REPS_W, 4: width of repeat count and repeat counter.

Ports:
- clk  in  1  clock. All state changes on posedge.
- rst  in  1  synchronous, active-high reset; highest priority.
- start  in  1  level-sampled; accepted only in IDLE.
- mode  in  1  0 = count up, 1 = count down. Latched on accepted start.
- load_val  in  WIDTH  run start value. Latched on accepted start.
- term_val  in  WIDTH  terminal value. Latched on accepted start.
- reps  in  REPS_W  runs to execute. 0 = repeat until abort. Latched on accepted start.
- pause  in  1  freeze counting while high.
- abort  in  1  terminate sequence without done.
- q  out  WIDTH  counter value. Registered; 0 after reset.
- busy  out  1  high in RUN or HOLD; 0 after reset.
- tick  out  1  registered one-cycle pulse per completed run; 0 after reset.
- done  out  1  one-cycle pulse in DONE state; 0 after reset.
- rep_cnt  out  REPS_W  completed runs in current sequence. Wraps mod 2^REPS_W. 0 after reset.

## Operation
- States: IDLE, RUN, HOLD, DONE. Reset state is IDLE.
- IDLE:
  - q holds its value.
  - When start=1: latch mode, load_val, term_val and reps; set q<=load_val and rep_cnt<=0; go to RUN.
- RUN, priority abort > pause > count:
  - abort: go to IDLE. q holds; no tick; no done.
  - pause: go to HOLD. q holds at this edge.
  - q != term: q <= q+1 (up) or q-1 (down), modulo 2^WIDTH. Wrap-around is legal, e.g. 15->0 up and 0->15 down.
  - q == term: tick<=1 and rep_cnt<=rep_cnt+1.
    - If reps != 0 and rep_cnt+1 == reps: go to DONE with q holding term.
    - Otherwise: q <= latched load_val and stay in RUN.
- HOLD:
  - abort: go to IDLE.
  - pause=0: go to RUN. No count on this edge.
  - Otherwise stay in HOLD with q frozen.
- DONE: done=1 and busy=0; go to IDLE on the next edge.
- start outside IDLE is ignored. Input changes after start are ignored until the next accepted start.
- Run length is dist+1 cycles:
  - up: dist = (term-load) mod 2^WIDTH.
  - down: dist = (load-term) mod 2^WIDTH.
  - load == term gives a 1-cycle run.
- rst=1 at any state or cycle forces IDLE and all outputs to reset values at that edge.

## Timing
- Start latency: start sampled at edge E0 gives q=load_val and busy=1 from E0.
- A sequence of N runs of length L occupies N*L RUN cycles, plus any HOLD cycles. This is followed by one DONE cycle, then IDLE.
- tick is high in the cycle after each q==term RUN cycle. That is the reload cycle, or the DONE cycle for the last run.
- done and busy are never high together.
- Earliest re-start is sampled at the first IDLE edge after DONE.

## Structure
- Package counter_seq_pkg:
  - state enum typedef (IDLE, RUN, HOLD, DONE).
  - MODE_UP=1'b0 and MODE_DOWN=1'b1 constants.
  - default WIDTH and REPS_W localparams.
- Sub-module sync_updown_counter:
  - WIDTH-bit register with load, load_val, en and dir inputs; mod-2^WIDTH arithmetic; synchronous reset to 0.
  - The FSM and latches live in counter_sequencer, which drives load/en/dir.

## Test plan
- Up, 2 runs: load=3, term=6, mode=0, reps=2, start 1 cycle. Expect q=3,4,5,6,3,4,5,6; tick 2x (cycles 5, 9); done at cycle 9; busy high 8 cycles; rep_cnt=2.
- Down wrap: load=1, term=14, mode=1, reps=1. Expect q=1,0,15,14; then DONE with q=14; one tick.
- Pause in RUN at q=5 for 3 cycles, up run 3->6. Expect q frozen at 5 during HOLD; no count on resume edge; tick deferred by 4 cycles.
- Abort on the cycle q==term, with reps=0. Expect IDLE next; no tick; no done; busy=0; q holds.
- Infinite plus edge cases:
  - reps=0, load==term=7: tick every cycle; rep_cnt wraps 15->0.
  - start during RUN is ignored.
- rst asserted mid-RUN while pause=1: next edge gives q=0, busy=0, tick=0, done=0, rep_cnt=0, state IDLE.
